// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, bus-drained exception flush sequencing, stall-cycle counter
module pipe_ctrl #(
    parameter int WAIT_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_inst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_data,
    input  logic        exception_i,
    input  logic [31:0] exception_pc_i,
    input  logic        ibus_busy,
    input  logic        dbus_busy,
    output logic [3:0]  stall,
    output logic        exception,
    output logic [31:0] flush_pc,
    output logic        flush_pending,
    output logic        bus_timeout,
    output logic [31:0] stall_cycles
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {RUN, WAIT, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt;
    logic            latch_pc;
    logic            set_timeout;
    logic            bus_idle;

    assign bus_idle = !ibus_busy && !dbus_busy;

    always_comb begin
        state_d       = state_q;
        stall         = 4'b0000;
        exception     = 1'b0;
        flush_pending = 1'b0;
        latch_pc      = 1'b0;
        set_timeout   = 1'b0;
        case (state_q)
            RUN: begin
                stall[0] = stallreq_data;
                stall[1] = stall[0] | stallreq_ex;
                stall[2] = stall[1] | stallreq_id;
                stall[3] = stall[2] | stallreq_inst;
                if (exception_i) begin
                    latch_pc = 1'b1;
                    state_d  = bus_idle ? FLUSH : WAIT;
                end
            end
            WAIT: begin
                stall         = 4'b1111;
                flush_pending = 1'b1;
                if (bus_idle) begin
                    state_d = FLUSH;
                end else if (wait_cnt == CW'(WAIT_MAX - 1)) begin
                    // Give up on a hung bus rather than stall the core forever.
                    state_d     = FLUSH;
                    set_timeout = 1'b1;
                end
            end
            FLUSH: begin
                exception = 1'b1;
                state_d   = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            wait_cnt     <= '0;
            flush_pc     <= 32'd0;
            bus_timeout  <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            state_q <= state_d;
            if (latch_pc) begin
                flush_pc <= exception_pc_i;
            end
            // Counter is held at zero outside WAIT so every drain starts fresh.
            if (state_q == WAIT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (set_timeout) begin
                bus_timeout <= 1'b1;
            end
            if (stall[3] && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a timeline-based reference model
module tb_pipe_ctrl;
    localparam int WMAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_inst, stallreq_id, stallreq_ex, stallreq_data;
    logic        exception_i;
    logic [31:0] exception_pc_i;
    logic        ibus_busy, dbus_busy;
    logic [3:0]  stall;
    logic        exception;
    logic [31:0] flush_pc;
    logic        flush_pending;
    logic        bus_timeout;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;
    int exp_sc   = 0;
    logic exp_to = 1'b0;

    pipe_ctrl #(.WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst),
        .stallreq_inst(stallreq_inst), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_data(stallreq_data),
        .exception_i(exception_i), .exception_pc_i(exception_pc_i),
        .ibus_busy(ibus_busy), .dbus_busy(dbus_busy),
        .stall(stall), .exception(exception), .flush_pc(flush_pc),
        .flush_pending(flush_pending), .bus_timeout(bus_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Request bits r = {inst, id, ex, data}; each stage stalls itself and everything upstream.
    function automatic logic [3:0] exp_stall(input logic [3:0] r);
        if (r[0]) return 4'b1111;
        if (r[1]) return 4'b1110;
        if (r[2]) return 4'b1100;
        if (r[3]) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reqs(input logic [3:0] r);
        {stallreq_inst, stallreq_id, stallreq_ex, stallreq_data} = r;
    endtask

    task automatic clear_inputs();
        set_reqs(4'b0000);
        exception_i = 1'b0; exception_pc_i = 32'd0;
        ibus_busy = 1'b0; dbus_busy = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        exp_sc = 0; exp_to = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (stall !== 4'b0000) begin failures++; $display("FAIL reset_stall c=%0d got=%b exp=0000", c, stall); end
            checks++; if (exception !== 1'b0) begin failures++; $display("FAIL reset_exception c=%0d got=%b exp=0", c, exception); end
            checks++; if (flush_pending !== 1'b0) begin failures++; $display("FAIL reset_pending c=%0d got=%b exp=0", c, flush_pending); end
            checks++; if (bus_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout c=%0d got=%b exp=0", c, bus_timeout); end
            checks++; if (flush_pc !== 32'd0) begin failures++; $display("FAIL reset_flush_pc c=%0d got=%h exp=0", c, flush_pc); end
            checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL reset_stall_cycles c=%0d got=%0d exp=0", c, stall_cycles); end
            tick();
        end
    endtask

    task automatic test_stall_merge();
        logic [3:0] r;
        logic [3:0] e;
        for (int c = 0; c < 40; c++) begin
            case (c)
                0: r = 4'b0010;
                1: r = 4'b0001;
                2: r = 4'b1000;
                default: r = 4'($urandom);
            endcase
            set_reqs(r);
            #1;
            e = exp_stall(r);
            checks++; if (stall !== e) begin failures++; $display("FAIL stall_merge c=%0d req=%b got=%b exp=%b", c, r, stall, e); end
            checks++; if (stall_cycles !== 32'(exp_sc)) begin failures++; $display("FAIL stall_count c=%0d got=%0d exp=%0d", c, stall_cycles, exp_sc); end
            if (e[3]) exp_sc++;
            tick();
        end
        clear_inputs();
    endtask

    // Bus(es) in bsel are busy for n cycles starting at the exception cycle T;
    // the flush lands at T+min(n,WMAX)+1, and a timeout is flagged only if n>WMAX.
    task automatic test_exception(input int n, input logic [1:0] bsel, input logic [31:0] pc);
        int f;
        logic [3:0] r;
        logic [3:0] e;
        f = ((n < WMAX) ? n : WMAX) + 1;
        r = 4'($urandom);
        set_reqs(r);
        exception_i = 1'b1; exception_pc_i = pc;
        ibus_busy = (n > 0) && bsel[0];
        dbus_busy = (n > 0) && bsel[1];
        #1;
        e = exp_stall(r);
        checks++; if (stall !== e) begin failures++; $display("FAIL exc_same_cycle_stall n=%0d got=%b exp=%b", n, stall, e); end
        checks++; if (exception !== 1'b0) begin failures++; $display("FAIL exc_early n=%0d got=%b exp=0", n, exception); end
        if (e[3]) exp_sc++;
        tick();
        for (int k = 1; k <= f + 1; k++) begin
            r = 4'($urandom);
            set_reqs(r);
            ibus_busy = (k < n) && bsel[0];
            dbus_busy = (k < n) && bsel[1];
            exception_i = (k < f) ? 1'($urandom_range(0, 1)) : 1'b0;
            exception_pc_i = $urandom;
            #1;
            checks++; if (stall_cycles !== 32'(exp_sc)) begin failures++; $display("FAIL exc_stall_count n=%0d k=%0d got=%0d exp=%0d", n, k, stall_cycles, exp_sc); end
            if (k < f) begin
                checks++; if (stall !== 4'b1111) begin failures++; $display("FAIL wait_stall n=%0d k=%0d got=%b exp=1111", n, k, stall); end
                checks++; if (flush_pending !== 1'b1) begin failures++; $display("FAIL wait_pending n=%0d k=%0d got=%b exp=1", n, k, flush_pending); end
                checks++; if (exception !== 1'b0) begin failures++; $display("FAIL wait_exception n=%0d k=%0d got=%b exp=0", n, k, exception); end
                checks++; if (bus_timeout !== exp_to) begin failures++; $display("FAIL wait_timeout n=%0d k=%0d got=%b exp=%b", n, k, bus_timeout, exp_to); end
                exp_sc++;
            end else if (k == f) begin
                if (n > WMAX) exp_to = 1'b1;
                checks++; if (exception !== 1'b1) begin failures++; $display("FAIL flush_pulse n=%0d k=%0d got=%b exp=1", n, k, exception); end
                checks++; if (flush_pc !== pc) begin failures++; $display("FAIL flush_pc n=%0d got=%h exp=%h", n, flush_pc, pc); end
                checks++; if (stall !== 4'b0000) begin failures++; $display("FAIL flush_stall n=%0d got=%b exp=0000", n, stall); end
                checks++; if (flush_pending !== 1'b0) begin failures++; $display("FAIL flush_pending n=%0d got=%b exp=0", n, flush_pending); end
                checks++; if (bus_timeout !== exp_to) begin failures++; $display("FAIL flush_timeout n=%0d got=%b exp=%b", n, bus_timeout, exp_to); end
            end else begin
                e = exp_stall(r);
                checks++; if (exception !== 1'b0) begin failures++; $display("FAIL post_flush_exception n=%0d got=%b exp=0", n, exception); end
                checks++; if (flush_pending !== 1'b0) begin failures++; $display("FAIL post_flush_pending n=%0d got=%b exp=0", n, flush_pending); end
                checks++; if (stall !== e) begin failures++; $display("FAIL post_flush_stall n=%0d got=%b exp=%b", n, stall, e); end
                checks++; if (bus_timeout !== exp_to) begin failures++; $display("FAIL sticky_timeout n=%0d got=%b exp=%b", n, bus_timeout, exp_to); end
                if (e[3]) exp_sc++;
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            test_exception(int'($urandom_range(0, WMAX + 3)), 2'($urandom_range(1, 3)), $urandom);
        end
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        exception_i = 1'b1; exception_pc_i = 32'h8000_0180; dbus_busy = 1'b1;
        tick();
        exception_i = 1'b0;
        tick(); tick();
        checks++; if (flush_pending !== 1'b1) begin failures++; $display("FAIL rst_wait_entered got=%b exp=1", flush_pending); end
        rst = 1'b1;
        tick();
        rst = 1'b0; dbus_busy = 1'b0;
        exp_sc = 0; exp_to = 1'b0;
        #1;
        checks++; if (flush_pending !== 1'b0) begin failures++; $display("FAIL rst_wait_pending got=%b exp=0", flush_pending); end
        checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL rst_wait_stall_cycles got=%0d exp=0", stall_cycles); end
        checks++; if (flush_pc !== 32'd0) begin failures++; $display("FAIL rst_wait_flush_pc got=%h exp=0", flush_pc); end
        checks++; if (bus_timeout !== 1'b0) begin failures++; $display("FAIL rst_wait_timeout got=%b exp=0", bus_timeout); end
        for (int c = 0; c < 6; c++) begin
            checks++; if (exception !== 1'b0) begin failures++; $display("FAIL rst_wait_no_pulse c=%0d got=%b exp=0", c, exception); end
            checks++; if (stall !== 4'b0000) begin failures++; $display("FAIL rst_wait_stall c=%0d got=%b exp=0000", c, stall); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_stall_merge();
        test_exception(0, 2'b01, 32'hBFC0_0380);
        test_exception(5, 2'b10, 32'h8000_0200);
        test_exception(20, 2'b01, 32'h8000_0300);
        test_exception(WMAX, 2'b11, 32'h8000_0400);
        test_back_to_back();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the five-stage core. It merges per-stage stall requests into the cumulative 4-bit stall vector consumed by every pipeline register (`{inst, id, ex, data}`). It sequences exception flushes so that a flush is issued only after outstanding instruction/data bus transactions have drained. It also keeps a saturating stall-cycle counter for performance runs.

## Interface

Parameters:
- WAIT_MAX, 64: maximum number of cycles spent draining the bus before a flush is forced.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- stallreq_inst  in  1  fetch is waiting on the instruction bus.
- stallreq_id  in  1  load-use hazard in decode.
- stallreq_ex  in  1  multicycle mult/div is busy.
- stallreq_data  in  1  memory stage is waiting on the data bus.
- exception_i  in  1  exception committed in the memory stage (single-cycle request).
- exception_pc_i  in  32  handler target PC; valid when exception_i=1.
- ibus_busy  in  1  instruction bus transaction outstanding.
- dbus_busy  in  1  data bus transaction outstanding.
- stall  out  4  bit3 inst, bit2 id, bit1 ex, bit0 data.
- exception  out  1  one-cycle flush pulse to all pipeline registers.
- flush_pc  out  32  redirect PC; meaningful while exception=1.
- flush_pending  out  1  an exception is latched and not yet flushed.
- bus_timeout  out  1  sticky flag: a drain hit WAIT_MAX.
- stall_cycles  out  32  saturating count of cycles with stall[3]=1.

## Operation

- FSM states: RUN, WAIT, FLUSH. Reset state is RUN.
- In RUN, the stall vector is combinational and cumulative:
  - stall[0] = stallreq_data
  - stall[1] = stall[0] | stallreq_ex
  - stall[2] = stall[1] | stallreq_id
  - stall[3] = stall[2] | stallreq_inst
- RUN with exception_i=1:
  - Latch exception_pc_i into flush_pc.
  - If ibus_busy=0 and dbus_busy=0, go to FLUSH; otherwise go to WAIT and clear the wait counter.
- WAIT:
  - stall forced to 4'b1111 and flush_pending=1.
  - The wait counter increments each cycle.
  - When both busy inputs are 0, go to FLUSH.
  - When the counter reaches WAIT_MAX-1 with a bus still busy, go to FLUSH and set bus_timeout.
- FLUSH:
  - exception=1 for exactly one cycle; stall=4'b0000; flush_pending=0. Next state is RUN.
- exception_i is ignored outside RUN; any new request is dropped.
- stall_cycles increments when stall[3]=1, saturates at 32'hFFFFFFFF, and never wraps.
- bus_timeout is cleared only by rst.

## Timing

- Reset values: state RUN, stall=0, exception=0, flush_pc=0, flush_pending=0, bus_timeout=0, stall_cycles=0, wait counter=0.
- Reset mid-WAIT or mid-FLUSH: return to RUN on the next edge with all outputs at reset values; the latched exception is discarded.
- Stall-path latency is 0: requests propagate combinationally to stall in RUN.
- exception and flush_pc are registered. With buses idle, exception_i at cycle T gives exception=1 at T+1 and RUN again at T+2.
- With a bus busy at T:
  - WAIT runs from T+1.
  - Let the first cycle sampling both busy inputs at 0 be D; then exception=1 at D+1.
  - Worst case: exception=1 at T+WAIT_MAX+1.
- flush_pending is 1 exactly during WAIT cycles.
- When exception_i and stall requests are high in the same RUN cycle, stall still reflects the requests for that cycle.

## Test plan

- Reset then idle: no requests -> stall=0000, exception=0, stall_cycles=0 over 10 cycles.
- Cumulative stall:
  - stallreq_ex=1 alone -> stall=1110.
  - stallreq_data=1 alone -> stall=1111.
  - stallreq_inst=1 alone -> stall=1000.
  - stall_cycles increases by 1 per stalled cycle.
- Idle-bus exception: exception_i=1 with exception_pc_i=32'hBFC00380 at T -> exception=1 and flush_pc=32'hBFC00380 at T+1 only; stall=0000 at T+1.
- Drain: exception at T with dbus_busy=1 held for 5 cycles -> stall=1111 and flush_pending=1 for T+1..T+5; exception=1 at T+6. A second exception_i during WAIT is ignored.
- Timeout: WAIT_MAX=8, ibus_busy stuck at 1 -> exception=1 at T+9 and bus_timeout=1, which stays set after return to RUN.
- Reset mid-WAIT: rst asserted at T+3 of a drain -> next cycle RUN, flush_pending=0, no exception pulse afterwards, stall_cycles=0.
